pll_lock_sequencer: RTL and testbench

Reset and lock sequencer for the board PLL that generates the 100/200/400 MHz TDC clocks. Runs on the free-running reference clock. Pulses the PLL reset at power-up and on request, waits for LOCKED to be stable, then releases the downstream domain reset. On loss of lock it takes the TDC logic back into reset and re-runs the lock sequence, counting retries and lock losses for the status registers.

---
 rtl/pll_lock_sequencer.sv | 159 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Reset and lock sequencer for the board PLL feeding the TDC clock domains.
// Pulses the PLL reset, waits for a stable lock, releases the downstream
// domain reset, and re-runs the sequence on lock loss or on request.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOCKED,
  input  logic       REQ_RELOCK,
  output logic       PLL_RST,
  output logic       DOMAIN_RST,
  output logic       READY,
  output logic [7:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT
);

  // One shared cycle counter sized for the longest interval it must span.
  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned STAT_W  = 8;

  localparam logic [CNT_W-1:0]  RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_SAT     = '1;

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             retry_inc;
  logic             loss_inc;
  logic             lock_meta;
  logic             locked_s;

  // Two-flop synchronizer: LOCKED is asynchronous to CLK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= LOCKED;
      locked_s  <= lock_meta;
    end
  end

  // State and cycle-counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_RESET_PLL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; a relock request outranks timeout and release,
  // and a lock loss in RUN outranks a coincident request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (REQ_RELOCK) begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
        end else if (locked_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
          retry_inc = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (REQ_RELOCK) begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
        end else if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
          loss_inc  = 1'b1;
        end else if (REQ_RELOCK) begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_RESET_PLL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Saturating status counters; cleared only by RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RETRY_CNT <= '0;
      LOSS_CNT  <= '0;
    end else begin
      if (retry_inc && (RETRY_CNT != STAT_SAT)) begin
        RETRY_CNT <= RETRY_CNT + STAT_W'(1);
      end
      if (loss_inc && (LOSS_CNT != STAT_SAT)) begin
        LOSS_CNT <= LOSS_CNT + STAT_W'(1);
      end
    end
  end

  // Registered Moore outputs decoded from the next state so they track state exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PLL_RST    <= 1'b1;
      DOMAIN_RST <= 1'b1;
      READY      <= 1'b0;
    end else begin
      PLL_RST    <= (state_nxt == S_RESET_PLL);
      DOMAIN_RST <= (state_nxt != S_RUN);
      READY      <= (state_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios followed by random
// LOCKED/REQ_RELOCK/RST traffic, every cycle checked against a phase model.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;

  logic       CLK;
  logic       RST;
  logic       LOCKED;
  logic       REQ_RELOCK;
  logic       PLL_RST;
  logic       DOMAIN_RST;
  logic       READY;
  logic [7:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: current phase, cycles spent in it, status counts,
  // and the two-cycle delay line that LOCKED goes through.
  int m_ph    = PH_PULSE;
  int m_e     = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit m_d1    = 1'b0;
  bit m_d2    = 1'b0;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOCKED    (LOCKED),
    .REQ_RELOCK(REQ_RELOCK),
    .PLL_RST   (PLL_RST),
    .DOMAIN_RST(DOMAIN_RST),
    .READY     (READY),
    .RETRY_CNT (RETRY_CNT),
    .LOSS_CNT  (LOSS_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic go(input int ph);
    m_ph = ph;
    m_e  = 0;
  endtask

  // Model update for one clock edge, given the inputs seen at that edge.
  task automatic model_edge(input logic rs, input logic lk, input logic rq);
    bit seen;
    if (rs) begin
      go(PH_PULSE);
      m_retry = 0;
      m_loss  = 0;
      m_d1    = 1'b0;
      m_d2    = 1'b0;
      return;
    end
    seen = m_d2;
    case (m_ph)
      PH_PULSE: begin
        m_e++;
        if (m_e == RST_CYCLES) go(PH_WAIT);
      end
      PH_WAIT: begin
        if (rq) go(PH_PULSE);
        else if (seen) go(PH_STABLE);
        else begin
          m_e++;
          if (m_e == LOCK_TIMEOUT) begin
            go(PH_PULSE);
            m_retry = sat(m_retry + 1);
          end
        end
      end
      PH_STABLE: begin
        if (rq) go(PH_PULSE);
        else if (!seen) go(PH_WAIT);
        else begin
          m_e++;
          if (m_e == STABLE_CYCLES) go(PH_RUN);
        end
      end
      default: begin
        if (!seen) begin
          go(PH_PULSE);
          m_loss = sat(m_loss + 1);
        end else if (rq) go(PH_PULSE);
      end
    endcase
    m_d2 = m_d1;
    m_d1 = lk;
  endtask

  // Drive inputs, take one edge, update the model, compare all outputs.
  task automatic tick(input logic rs, input logic lk, input logic rq);
    RST        = rs;
    LOCKED     = lk;
    REQ_RELOCK = rq;
    @(posedge CLK);
    model_edge(rs, lk, rq);
    #1;
    chk("pll_rst",    32'(PLL_RST),    32'(m_ph == PH_PULSE));
    chk("domain_rst", 32'(DOMAIN_RST), 32'(m_ph != PH_RUN));
    chk("ready",      32'(READY),      32'(m_ph == PH_RUN));
    chk("retry_cnt",  32'(RETRY_CNT),  32'(m_retry));
    chk("loss_cnt",   32'(LOSS_CNT),   32'(m_loss));
    chk("dom_low_while_pll_rst", 32'(PLL_RST && !DOMAIN_RST), 32'(0));
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!READY && n < budget) begin
      tick(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk({tag, "_ready_timeout"}, 32'(READY), 32'(1));
  endtask

  initial begin
    int w;
    int rose;
    int last_rise;
    bit prev;
    bit seen_rdy;
    bit seen_pll;
    logic lk;
    logic rq;
    logic rs;

    RST = 1'b1; LOCKED = 1'b1; REQ_RELOCK = 1'b0;

    // Reset state
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    chk("rst_pll_rst", 32'(PLL_RST), 32'(1));
    chk("rst_domain",  32'(DOMAIN_RST), 32'(1));
    chk("rst_ready",   32'(READY), 32'(0));
    chk("rst_retry",   32'(RETRY_CNT), 32'(0));
    chk("rst_loss",    32'(LOSS_CNT), 32'(0));

    // Power-up with LOCKED already high
    w = PLL_RST ? 1 : 0;
    rose = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (PLL_RST) w++;
      if (READY && rose < 0) rose = i + 1;
    end
    chk("pwrup_pulse_width", 32'(w), 32'(RST_CYCLES));
    chk("pwrup_ready_edge",  32'(rose), 32'(RST_CYCLES + 1 + STABLE_CYCLES));
    chk("pwrup_counters",    32'({RETRY_CNT, LOSS_CNT}), 32'(0));

    // Lock loss in RUN: visible two edges after the low sample
    tick(1'b0, 1'b0, 1'b0);
    chk("loss_m_ready", 32'(READY), 32'(1));
    tick(1'b0, 1'b1, 1'b0);
    chk("loss_m1_ready", 32'(READY), 32'(1));
    tick(1'b0, 1'b1, 1'b0);
    chk("loss_m2_ready",   32'(READY), 32'(0));
    chk("loss_m2_pll_rst", 32'(PLL_RST), 32'(1));
    chk("loss_m2_count",   32'(LOSS_CNT), 32'(1));
    wait_ready("loss", 100);

    // Relock request in RUN, then a request during the PLL pulse
    tick(1'b0, 1'b1, 1'b1);
    chk("req_run_domain",  32'(DOMAIN_RST), 32'(1));
    chk("req_run_pll_rst", 32'(PLL_RST), 32'(1));
    chk("req_run_loss",    32'(LOSS_CNT), 32'(1));
    w = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'(i < 2));
      if (PLL_RST) w++;
    end
    chk("req_pulse_width", 32'(w), 32'(RST_CYCLES));
    wait_ready("req", 100);

    // Request coincident with a lock drop seen in RUN
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("coinc_loss", 32'(LOSS_CNT), 32'(2));
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    wait_ready("coinc", 100);
    chk("coinc_loss_hold", 32'(LOSS_CNT), 32'(2));

    // One-cycle lock glitch during STABLE
    tick(1'b0, 1'b1, 1'b1);
    w = 0;
    while (PLL_RST && w < 20) begin
      tick(1'b0, 1'b0, 1'b0);
      w++;
    end
    chk("glitch_enter_wait", 32'(PLL_RST), 32'(0));
    rose = -1;
    seen_pll = 1'b0;
    for (int j = 0; j < 30; j++) begin
      tick(1'b0, 1'(j != 5), 1'b0);
      if (PLL_RST) seen_pll = 1'b1;
      if (READY && rose < 0) rose = j;
    end
    chk("glitch_no_pll_rst", 32'(seen_pll), 32'(0));
    chk("glitch_ready_edge", 32'(rose), 32'(6 + 2 + STABLE_CYCLES));
    chk("glitch_retry",      32'(RETRY_CNT), 32'(0));
    chk("glitch_loss",       32'(LOSS_CNT), 32'(2));

    // LOCKED held low: periodic retries, saturating retry count
    prev = PLL_RST;
    last_rise = -1;
    seen_rdy = 1'b0;
    w = 0;
    for (int i = 0; i < 9300; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (READY && i >= 2) seen_rdy = 1'b1;
      if (PLL_RST && !prev) begin
        if (last_rise >= 0) chk("retry_period", 32'(i - last_rise), 32'(RST_CYCLES + LOCK_TIMEOUT));
        last_rise = i;
        w = 1;
      end else if (PLL_RST) begin
        w++;
      end else if (prev) begin
        chk("retry_pulse_width", 32'(w), 32'(RST_CYCLES));
      end
      prev = PLL_RST;
    end
    chk("retry_saturated",  32'(RETRY_CNT), 32'(255));
    chk("retry_no_ready",   32'(seen_rdy), 32'(0));
    chk("retry_loss",       32'(LOSS_CNT), 32'(3));

    // RST while in STABLE with both counters nonzero
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    w = 0;
    while (PLL_RST && w < 50) begin
      tick(1'b0, 1'b1, 1'b0);
      w++;
    end
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    chk("pre_rst_not_ready", 32'(READY), 32'(0));
    tick(1'b1, 1'b1, 1'b0);
    chk("midrst_pll_rst", 32'(PLL_RST), 32'(1));
    chk("midrst_ready",   32'(READY), 32'(0));
    chk("midrst_domain",  32'(DOMAIN_RST), 32'(1));
    chk("midrst_retry",   32'(RETRY_CNT), 32'(0));
    chk("midrst_loss",    32'(LOSS_CNT), 32'(0));

    // Random traffic against the model
    lk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      rq = 1'($urandom_range(0, 99) == 0);
      rs = 1'($urandom_range(0, 1499) == 0);
      tick(rs, lk, rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
